// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame streamer.
// The TRL state exists only when FRAME_STREAM_CHECKSUM_EN is defined.
package frame_stream_pkg;

    localparam int         HDR_LEN   = 4;
    localparam logic [7:0] HDR_SYNC0 = 8'hA5;
    localparam logic [7:0] HDR_SYNC1 = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        WAIT,
        SEND_HI,
        SEND_LO,
`ifdef FRAME_STREAM_CHECKSUM_EN
        TRL,
`endif
        FIN
    } state_t;

    // Header byte sel of the frame header: two sync bytes, then the pixel count MSB first.
    function automatic logic [7:0] hdr_byte(input logic [1:0] sel, input logic [15:0] npix);
        case (sel)
            2'd0:    return HDR_SYNC0;
            2'd1:    return HDR_SYNC1;
            2'd2:    return npix[15:8];
            default: return npix[7:0];
        endcase
    endfunction

endpackage

// File: rtl/frame_stream_ctrl_if.sv
// Control, frame-buffer read port and UART byte stream of the frame streamer.
interface frame_stream_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              frame_lock;
    logic [ADDR_W-1:0] bram_addrb;
    logic [15:0]       bram_doutb;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              cts_n;

    modport master (
        input  start, abort, bram_doutb, tx_ready, cts_n,
        output busy, done, frame_lock, bram_addrb, tx_data, tx_valid
    );

    modport slave (
        output start, abort, bram_doutb, tx_ready, cts_n,
        input  busy, done, frame_lock, bram_addrb, tx_data, tx_valid
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to 1 so an unknown flow-control line reads as "hold off".
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/frame_stream_ctrl.sv
// Streams one frame from the frame buffer to the UART: 4-byte header, then each pixel MSB first.
// Defining FRAME_STREAM_CHECKSUM_EN appends a mod-256 sum of the pixel bytes.
module frame_stream_ctrl
    import frame_stream_pkg::*;
#(
    parameter int FRAME_PIXELS = 19200,
    parameter int ADDR_W       = 15,
    parameter int PIXEL_W      = 16
) (
    input  logic                sysclk,
    input  logic                sysreset_n,
    frame_stream_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [15:0]       NPIX     = 16'(FRAME_PIXELS);
    localparam logic [1:0]        HDR_LAST = 2'(HDR_LEN - 1);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_lock;
    logic               r_tx_valid;
    logic [7:0]         r_tx_data;
    logic [ADDR_W-1:0]  r_idx;
    logic [1:0]         r_hcnt;
    logic [PIXEL_W-1:0] r_pix;
`ifdef FRAME_STREAM_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    logic       w_cts_n;
    logic       w_byte_st;
    logic [7:0] w_cur_byte;

    sync2 u_cts_sync (
        .i_clk   (sysclk),
        .i_rst_n (sysreset_n),
        .i_d     (bus.cts_n),
        .o_q     (w_cts_n)
    );

    always_comb begin
        w_byte_st  = 1'b0;
        w_cur_byte = 8'h00;
        case (r_state)
            HDR:     begin w_byte_st = 1'b1; w_cur_byte = hdr_byte(r_hcnt, NPIX); end
            SEND_HI: begin w_byte_st = 1'b1; w_cur_byte = r_pix[15:8];            end
            SEND_LO: begin w_byte_st = 1'b1; w_cur_byte = r_pix[7:0];             end
`ifdef FRAME_STREAM_CHECKSUM_EN
            TRL:     begin w_byte_st = 1'b1; w_cur_byte = r_csum;                 end
`endif
            default: begin w_byte_st = 1'b0; w_cur_byte = 8'h00;                  end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lock     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_idx      <= '0;
            r_hcnt     <= '0;
`ifdef FRAME_STREAM_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= HDR;
                    r_busy  <= 1'b1;
                    r_lock  <= 1'b1;
                    r_idx   <= '0;
                    r_hcnt  <= '0;
`ifdef FRAME_STREAM_CHECKSUM_EN
                    r_csum  <= 8'h00;
`endif
                end
                FETCH: if (bus.abort) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_lock  <= 1'b0;
                end else begin
                    r_state <= WAIT;
                end
                WAIT: if (bus.abort) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_lock  <= 1'b0;
                end else begin
                    r_pix   <= bus.bram_doutb;
                    r_state <= SEND_HI;
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_lock  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: if (!w_byte_st) begin
                    r_state <= IDLE;
                end else if (!r_tx_valid) begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_lock  <= 1'b0;
                    end else if (!w_cts_n) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_cur_byte;
                    end
                end else if (bus.tx_ready) begin
                    // Handshake: retire the byte; the next byte of the same pixel/header is
                    // offered in this same cycle so a held-high tx_ready sees no gap.
                    r_tx_valid <= 1'b0;
`ifdef FRAME_STREAM_CHECKSUM_EN
                    if (r_state == SEND_HI || r_state == SEND_LO)
                        r_csum <= r_csum + r_tx_data;
`endif
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_lock  <= 1'b0;
                    end else begin
                        case (r_state)
                            HDR: if (r_hcnt == HDR_LAST) begin
                                r_state <= FETCH;
                            end else begin
                                r_hcnt <= r_hcnt + 2'd1;
                                if (!w_cts_n) begin
                                    r_tx_valid <= 1'b1;
                                    r_tx_data  <= hdr_byte(r_hcnt + 2'd1, NPIX);
                                end
                            end
                            SEND_HI: begin
                                r_state <= SEND_LO;
                                if (!w_cts_n) begin
                                    r_tx_valid <= 1'b1;
                                    r_tx_data  <= r_pix[7:0];
                                end
                            end
                            SEND_LO: if (r_idx == LAST_IDX) begin
`ifdef FRAME_STREAM_CHECKSUM_EN
                                r_state <= TRL;
`else
                                r_state <= FIN;
`endif
                            end else begin
                                r_idx   <= r_idx + ADDR_W'(1);
                                r_state <= FETCH;
                            end
`ifdef FRAME_STREAM_CHECKSUM_EN
                            TRL:     r_state <= FIN;
`endif
                            default: r_state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.frame_lock = r_lock;
    assign bus.bram_addrb = r_idx;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Directed bench for frame_stream_ctrl with a 4-pixel frame; honours FRAME_STREAM_CHECKSUM_EN.
module tb_frame_stream_ctrl;

`ifdef FRAME_STREAM_CHECKSUM_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif

    logic sysclk = 1'b0;
    logic sysreset_n;
    always #5 sysclk = ~sysclk;

    frame_stream_ctrl_if #(.ADDR_W(4)) bus ();

    frame_stream_ctrl #(.FRAME_PIXELS(4), .ADDR_W(4), .PIXEL_W(16)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .bus        (bus)
    );

    logic [15:0] mem [16];
    logic [7:0]  exp_bytes [13] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h12, 8'h34,
                                    8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
    logic [7:0]  cap [$];
    int          cap_cyc [$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge sysclk) bus.bram_doutb <= mem[bus.bram_addrb];

    always @(posedge sysclk) begin
        cyc++;
        if (bus.tx_valid && bus.tx_ready) begin
            cap.push_back(bus.tx_data);
            cap_cyc.push_back(cyc);
        end
        if (bus.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge sysclk);
        bus.start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check($sformatf("wait_bytes_%0d", n), 32'(cap.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!bus.tx_valid && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check("wait_valid", 32'(bus.tx_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge sysclk);
            k++;
        end
        check("wait_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(cap.size()), 32'(NB));
        for (int i = 0; i < NB && i < cap.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_bytes[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(bus.busy),       32'd0);
        check({tag, "_done"},  32'(bus.done),       32'd0);
        check({tag, "_lock"},  32'(bus.frame_lock), 32'd0);
        check({tag, "_valid"}, 32'(bus.tx_valid),   32'd0);
        check({tag, "_data"},  32'(bus.tx_data),    32'd0);
        check({tag, "_addr"},  32'(bus.bram_addrb), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        logic [7:0] held;

        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
        sysreset_n   = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.tx_ready = 1'b1;
        bus.cts_n    = 1'b0;
        repeat (3) @(negedge sysclk);
        check_reset_outputs("rst");
        sysreset_n = 1'b1;
        repeat (3) @(negedge sysclk);

        // Frame 1: normal stream, with a second start mid-frame that must be ignored
        cap.delete(); cap_cyc.delete();
        pulse_start();
        check("f1_busy", 32'(bus.busy), 32'd1);
        check("f1_lock", 32'(bus.frame_lock), 32'd1);
        wait_bytes(6, 100);
        pulse_start();
        wait_idle(200);
        check("f1_done_hi", 32'(bus.done), 32'd1);
        check("f1_lock_lo", 32'(bus.frame_lock), 32'd0);
        check_stream("f1");
        check("f1_hdr_b2b", 32'(cap_cyc[1] - cap_cyc[0]), 32'd1);
        @(negedge sysclk);
        check("f1_done_lo", 32'(bus.done), 32'd0);
        check("f1_done_cnt", 32'(done_cnt), 32'd1);
        check("f1_no_restart", 32'(cap.size()), 32'(NB));

        // Frame 2: start one cycle after done; cts_n flow control after byte 6
        cap.delete(); cap_cyc.delete();
        pulse_start();
        check("f2_busy", 32'(bus.busy), 32'd1);
        wait_bytes(6, 100);
        bus.cts_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge sysclk);
            if (bus.tx_valid) bad++;
        end
        check("f2_paused", 32'(bad), 32'd0);
        check("f2_paused_len", 32'(cap.size()), 32'd6);
        bus.cts_n = 1'b0;
        @(negedge sysclk);
        check("f2_sync_lat1", 32'(bus.tx_valid), 32'd0);
        @(negedge sysclk);
        check("f2_sync_lat2", 32'(bus.tx_valid), 32'd0);
        @(negedge sysclk);
        check("f2_resume_valid", 32'(bus.tx_valid), 32'd1);
        check("f2_resume_data", 32'(bus.tx_data), 32'hAB);
        wait_idle(200);
        check_stream("f2");
        @(negedge sysclk);
        check("f2_done_cnt", 32'(done_cnt), 32'd2);

        // Frame 3: tx_ready low for 10 cycles on a pending pixel byte
        cap.delete(); cap_cyc.delete();
        pulse_start();
        wait_bytes(6, 100);
        bus.tx_ready = 1'b0;
        wait_valid(50);
        held = bus.tx_data;
        check("f3_held", 32'(held), 32'hAB);
        bad = 0;
        repeat (10) begin
            @(negedge sysclk);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) bad++;
        end
        check("f3_stable", 32'(bad), 32'd0);
        check("f3_stalled_len", 32'(cap.size()), 32'd6);
        bus.tx_ready = 1'b1;
        wait_idle(200);
        check_stream("f3");
        @(negedge sysclk);
        check("f3_done_cnt", 32'(done_cnt), 32'd3);

        // Frame 4: abort while the pixel-2 high byte is pending
        cap.delete(); cap_cyc.delete();
        pulse_start();
        wait_bytes(8, 100);
        bus.tx_ready = 1'b0;
        wait_valid(50);
        check("f4_pending", 32'(bus.tx_data), 32'h00);
        bus.abort = 1'b1;
        repeat (3) @(negedge sysclk);
        check("f4_hold_valid", 32'(bus.tx_valid), 32'd1);
        check("f4_hold_data", 32'(bus.tx_data), 32'h00);
        check("f4_hold_busy", 32'(bus.busy), 32'd1);
        bus.tx_ready = 1'b1;
        @(negedge sysclk);
        check("f4_busy", 32'(bus.busy), 32'd0);
        check("f4_lock", 32'(bus.frame_lock), 32'd0);
        check("f4_valid", 32'(bus.tx_valid), 32'd0);
        check("f4_len", 32'(cap.size()), 32'd9);
        bus.abort = 1'b0;
        repeat (20) @(negedge sysclk);
        check("f4_len_after", 32'(cap.size()), 32'd9);
        check("f4_no_done", 32'(done_cnt), 32'd3);

        // Frame 5: reset during SEND_LO of pixel 1
        cap.delete(); cap_cyc.delete();
        pulse_start();
        wait_bytes(7, 100);
        check("f5_addr_pre", 32'(bus.bram_addrb), 32'd1);
        sysreset_n   = 1'b0;
        bus.tx_ready = 1'b0;
        @(negedge sysclk);
        check_reset_outputs("f5_rst");
        sysreset_n   = 1'b1;
        bus.tx_ready = 1'b1;
        repeat (20) @(negedge sysclk);
        check("f5_len", 32'(cap.size()), 32'd7);
        check("f5_busy", 32'(bus.busy), 32'd0);
        check("f5_valid", 32'(bus.tx_valid), 32'd0);
        check("f5_no_done", 32'(done_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
